// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-Lite register file: response codes and FSM states.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_COLLECT = 1'b0,
        W_RESP    = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_ADDR = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bus bundle with master and slave views.
interface axi_lite_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_regfile_mem.sv
// Register storage: one byte-enable write port, one registered read port.
module axi_lite_regfile_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_idx,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/8-1:0]        wr_strb,
    input  logic                       rd_en,
    input  logic                       rd_zero,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [DATA_W-1:0]          rd_data
);

    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Byte-lane writes; reset clears every register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read data is captured at address acceptance, so a same-edge write is not seen.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= rd_zero ? '0 : mem_q[rd_idx];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI-Lite slave register file: address decode plus independent write and read FSMs.
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32
) (
    input  logic       aclk,
    input  logic       areset,
    axi_lite_if.slave  s_axi_lite
);

    localparam int unsigned OFFS   = $clog2(DATA_W / 8);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned FULL_W = ADDR_W - OFFS;

    wr_state_t wstate_q, wstate_d;
    rd_state_t rstate_q, rstate_d;
    logic      live_q;
    logic      aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    resp_t     bresp_q, bresp_d, rresp_q, rresp_d;

    logic              awready_c, wready_c, arready_c, aw_hs, w_hs, ar_hs;
    logic              wr_commit, wr_in_range, rd_in_range;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic [FULL_W-1:0] wr_full, rd_full;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_addr_lsbs;

    // Readies stay low until the first edge after reset is released.
    assign awready_c = live_q && (wstate_q == W_COLLECT) && !aw_held_q;
    assign wready_c  = live_q && (wstate_q == W_COLLECT) && !w_held_q;
    assign arready_c = live_q && (rstate_q == R_ADDR);
    assign aw_hs     = s_axi_lite.awvalid && awready_c;
    assign w_hs      = s_axi_lite.wvalid && wready_c;
    assign ar_hs     = s_axi_lite.arvalid && arready_c;

    // A held beat takes priority; otherwise the live beat completing this cycle is used.
    assign wr_addr = aw_held_q ? awaddr_q : s_axi_lite.awaddr;
    assign wr_data = w_held_q ? wdata_q : s_axi_lite.wdata;
    assign wr_strb = w_held_q ? wstrb_q : s_axi_lite.wstrb;

    assign wr_full     = wr_addr[ADDR_W-1:OFFS];
    assign rd_full     = s_axi_lite.araddr[ADDR_W-1:OFFS];
    assign wr_in_range = (wr_full >> IDX_W) == '0;
    assign rd_in_range = (rd_full >> IDX_W) == '0;

    assign unused_addr_lsbs = ^{wr_addr[OFFS-1:0], s_axi_lite.araddr[OFFS-1:0]};

    // Write FSM: collect AW and W in any order, commit when both present, then respond.
    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        wr_commit = 1'b0;
        unique case (wstate_q)
            W_COLLECT: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_axi_lite.awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axi_lite.wdata;
                    wstrb_d  = s_axi_lite.wstrb;
                end
                if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
                    wr_commit = 1'b1;
                    wstate_d  = W_RESP;
                    bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
                end
            end
            W_RESP: begin
                if (s_axi_lite.bready) begin
                    wstate_d  = W_COLLECT;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
        endcase
    end

    // Read FSM: accept an address, then hold the registered response until taken.
    always_comb begin
        rstate_d = rstate_q;
        rresp_d  = rresp_q;
        unique case (rstate_q)
            R_ADDR: begin
                if (ar_hs) begin
                    rstate_d = R_DATA;
                    rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: begin
                if (s_axi_lite.rready) begin
                    rstate_d = R_ADDR;
                end
            end
        endcase
    end

    // State registers for both paths.
    always_ff @(posedge aclk) begin
        if (areset) begin
            live_q    <= 1'b0;
            wstate_q  <= W_COLLECT;
            rstate_q  <= R_ADDR;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
        end else begin
            live_q    <= 1'b1;
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
        end
    end

    axi_lite_regfile_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .aclk    (aclk),
        .areset  (areset),
        .wr_en   (wr_commit && wr_in_range),
        .wr_idx  (wr_full[IDX_W-1:0]),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_en   (ar_hs),
        .rd_zero (!rd_in_range),
        .rd_idx  (rd_full[IDX_W-1:0]),
        .rd_data (mem_rdata)
    );

    assign s_axi_lite.awready = awready_c;
    assign s_axi_lite.wready  = wready_c;
    assign s_axi_lite.bvalid  = (wstate_q == W_RESP);
    assign s_axi_lite.bresp   = bresp_q;
    assign s_axi_lite.arready = arready_c;
    assign s_axi_lite.rvalid  = (rstate_q == R_DATA);
    assign s_axi_lite.rresp   = rresp_q;
    assign s_axi_lite.rdata   = mem_rdata;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile with a per-cycle compare against a register model.
module tb_axi_lite_regfile;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_regfile #(.ADDR_W(32), .DATA_W(32), .DEPTH(32)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .s_axi_lite (bus)
    );

    int total = 0;
    int bad = 0;

    logic [31:0] model [32];
    logic        b_pend = 1'b0;
    logic        r_pend = 1'b0;
    logic [1:0]  exp_bresp = 2'b00;
    logic [1:0]  exp_rresp = 2'b00;
    logic [31:0] exp_rdata = 32'h0;
    logic        checking = 1'b0;
    logic        rst_prev;
    logic [31:0] got, got2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a >> 2) < 32;
    endfunction

    always @(posedge aclk) rst_prev <= areset;

    // Per-cycle check of response channels against the model's expectations.
    always @(negedge aclk) begin
        if (checking) begin
            if (rst_prev) begin
                chk("reset_outputs",
                    {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid,
                     bus.bresp, bus.rresp, bus.rdata}, 64'h0);
            end else begin
                chk("bvalid", bus.bvalid, b_pend);
                if (bus.bvalid) begin
                    chk("bresp", bus.bresp, exp_bresp);
                    chk("aw_w_ready_in_resp", {bus.awready, bus.wready}, 2'b00);
                end
                chk("rvalid", bus.rvalid, r_pend);
                if (bus.rvalid) begin
                    chk("rdata", bus.rdata, exp_rdata);
                    chk("rresp", bus.rresp, exp_rresp);
                    chk("arready_in_data", bus.arready, 1'b0);
                end
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int aw_dly, input int w_dly, input int b_hold);
        bit aw_done = 0, w_done = 0, aw_go, w_go, go = 0;
        int c = 0;
        int idx;
        bus.bready = 1'b0;
        while (!(aw_done && w_done) && c < 50) begin
            if (!aw_done && c >= aw_dly) begin bus.awvalid = 1'b1; bus.awaddr = a; end
            if (!w_done && c >= w_dly) begin
                bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = s;
            end
            @(negedge aclk);
            aw_go = bus.awvalid && bus.awready;
            w_go  = bus.wvalid && bus.wready;
            @(posedge aclk); #1;
            if (aw_go) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_go)  begin w_done = 1;  bus.wvalid = 1'b0; end
            c++;
        end
        chk("aw_w_handshake", {aw_done, w_done}, 2'b11);
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b0;
        if (!(aw_done && w_done)) return;
        idx = int'(a >> 2);
        if (in_range(a)) begin
            for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
        end
        exp_bresp = in_range(a) ? 2'b00 : 2'b10;
        b_pend = 1'b1;
        repeat (b_hold) begin @(posedge aclk); #1; end
        bus.bready = 1'b1;
        c = 0;
        while (!go && c < 20) begin
            @(negedge aclk);
            go = bus.bvalid;
            @(posedge aclk); #1;
            c++;
        end
        chk("b_handshake", go, 1'b1);
        b_pend = 1'b0;
        bus.bready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input int r_hold, output logic [31:0] data);
        bit go = 0;
        int c = 0;
        data = 32'hx;
        exp_rdata = in_range(a) ? model[int'(a >> 2)] : 32'h0;
        exp_rresp = in_range(a) ? 2'b00 : 2'b10;
        bus.rready = 1'b0;
        bus.arvalid = 1'b1;
        bus.araddr = a;
        while (!go && c < 20) begin
            @(negedge aclk);
            go = bus.arready;
            @(posedge aclk); #1;
            c++;
        end
        bus.arvalid = 1'b0;
        chk("ar_handshake", go, 1'b1);
        if (!go) return;
        r_pend = 1'b1;
        repeat (r_hold) begin @(posedge aclk); #1; end
        bus.rready = 1'b1;
        go = 0;
        c = 0;
        while (!go && c < 20) begin
            @(negedge aclk);
            go = bus.rvalid;
            data = bus.rdata;
            @(posedge aclk); #1;
            c++;
        end
        chk("r_handshake", go, 1'b1);
        r_pend = 1'b0;
        bus.rready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        bus.awvalid = 0; bus.awaddr = 0; bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0;
        bus.bready = 0; bus.arvalid = 0; bus.araddr = 0; bus.rready = 0;

        // Reset and release; readies come up one cycle after the release edge.
        repeat (3) @(posedge aclk);
        #1 checking = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("ready_before_release_edge", {bus.awready, bus.wready, bus.arready}, 3'b000);
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("ready_after_release", {bus.awready, bus.wready, bus.arready}, 3'b111);
        @(posedge aclk); #1;

        // Simultaneous AW/W.
        wr(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        rd(32'h08, 0, got);
        chk("lit_simul_write", got, 32'hDEADBEEF);

        // Zero strobe leaves data alone.
        wr(32'h08, 32'h12345678, 4'h0, 0, 0, 0);
        rd(32'h08, 0, got);
        chk("lit_zero_strobe", got, 32'hDEADBEEF);

        // W three cycles ahead of AW, partial strobe.
        wr(32'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0);
        wr(32'h04, 32'h11223344, 4'h3, 3, 0, 0);
        rd(32'h04, 0, got);
        chk("lit_w_first_strobe", got, 32'hAABB3344);

        // AW ahead of W.
        wr(32'h14, 32'hCAFEF00D, 4'hF, 0, 2, 0);
        rd(32'h14, 0, got);
        chk("lit_aw_first", got, 32'hCAFEF00D);

        // Out of range write leaves every register unchanged; read errors with zero data.
        wr(32'h80, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        for (int i = 0; i < 32; i++) rd(32'(i * 4), 0, got);
        rd(32'h80, 0, got);
        chk("lit_oor_rdata", got, 32'h0);

        // Backpressure on both response channels.
        wr(32'h10, 32'h0F0F0F0F, 4'hF, 0, 0, 5);
        rd(32'h10, 5, got);
        chk("lit_backpressure", got, 32'h0F0F0F0F);

        // Same-cycle read and write of one register returns the old value.
        wr(32'h0C, 32'h9, 4'hF, 0, 0, 0);
        fork
            wr(32'h0C, 32'h5, 4'hF, 0, 0, 0);
            rd(32'h0C, 0, got2);
        join
        chk("lit_collision_old", got2, 32'h9);
        rd(32'h0C, 0, got);
        chk("lit_collision_new", got, 32'h5);

        // Reset after AW only: transaction abandoned, all storage cleared.
        bus.awvalid = 1'b1;
        bus.awaddr = 32'h14;
        @(negedge aclk);
        chk("aw_ready_pre_reset", bus.awready, 1'b1);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        areset = 1'b1;
        repeat (2) begin @(posedge aclk); #1; end
        areset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(negedge aclk);
        chk("ready_low_at_release", {bus.awready, bus.wready, bus.arready}, 3'b000);
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("ready_after_mid_reset", {bus.awready, bus.wready, bus.arready}, 3'b111);
        @(posedge aclk); #1;
        repeat (3) begin @(posedge aclk); #1; end
        rd(32'h14, 0, got);
        chk("lit_reset_cleared", got, 32'h0);
        wr(32'h18, 32'h00A0B0C0, 4'hF, 0, 0, 0);
        rd(32'h18, 0, got);
        chk("lit_post_reset_write", got, 32'h00A0B0C0);

        repeat (2) @(posedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_lite_regfile.md
AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AXI-Lite address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width, one of 32 or 64.
REQ-003 SHALL have parameter DEPTH, default 32: number of DATA_W-bit registers, power of two, at least 2.
REQ-004 SHALL have port aclk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-005 SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port s_axi_lite, slave modport of axi_lite_if #(ADDR_W, DATA_W): AW, W, B, AR and R channels.
REQ-007 The interface SHALL carry wstrb of width DATA_W/8; bresp and rresp are 2 bits each.

Function
REQ-008 Byte address to index: idx = addr[ADDR_W-1 : log2(DATA_W/8)]; the low log2(DATA_W/8) bits are ignored.
REQ-009 idx < DEPTH is in range; idx >= DEPTH is out of range.
REQ-010 Read and write paths SHALL be independent FSMs that run concurrently.
REQ-011 Write FSM states: W_COLLECT and W_RESP.
REQ-012 In W_COLLECT: awready = !aw_held and wready = !w_held.
REQ-013 An AW handshake SHALL capture awaddr; a W handshake SHALL capture wdata and wstrb. AW and W complete in either order, or in the same cycle.
REQ-014 In the cycle the second of AW/W completes (held or live), the write SHALL commit at the clock edge and the FSM SHALL go to W_RESP.
REQ-015 For an in-range write, only bytes whose wstrb bit is 1 SHALL update; bresp = OKAY (2'b00).
REQ-016 For an out-of-range write, no register SHALL change; bresp = SLVERR (2'b10).
REQ-017 In W_RESP: bvalid = 1, and awready = wready = 0.
REQ-018 bvalid and bresp SHALL stay stable until bready; on the bvalid & bready edge, return to W_COLLECT and clear the held flags.
REQ-019 Read FSM states: R_ADDR and R_DATA.
REQ-020 In R_ADDR: arready = 1. On an AR handshake, rdata and rresp SHALL be registered and the FSM SHALL go to R_DATA.
REQ-021 In R_DATA: rvalid = 1 and arready = 0. Hold rdata/rresp until rready; on rvalid & rready return to R_ADDR.
REQ-022 For an out-of-range read: rdata = 0 and rresp = SLVERR.
REQ-023 Latency: handshake at cycle N gives bvalid/rvalid at cycle N+1. Peak throughput is one transaction per 2 cycles per path.
REQ-024 Collision: a read registered in the same cycle as a write commit to the same index SHALL return the pre-write value.
REQ-025 Zero wstrb SHALL still give bvalid with OKAY and leave data unchanged.

Reset
REQ-026 While areset = 1 at a clock edge, the following SHALL clear: all registers to 0, the held flags, and all outputs (awready, wready, bvalid, arready, rvalid, rdata, bresp, rresp) to 0.
REQ-027 After reset, the FSMs SHALL be in W_COLLECT/R_ADDR and ready SHALL assert the cycle after release.
REQ-028 Reset mid-transaction SHALL abandon that transaction with no register write and no response.

Structure
REQ-029 axi_lite_pkg SHALL hold RESP_OKAY/RESP_SLVERR as a resp_t enum, plus the write and read state enums.
REQ-030 Storage SHALL be one sub-module, axi_lite_regfile_mem: one byte-enable write port and one registered read port, parameterised by DATA_W and DEPTH.
REQ-031 Address decode and both FSMs SHALL live in axi_lite_regfile.

Verification
REQ-032 Simultaneous AW/W: awaddr 0x08, wdata 0xDEADBEEF, wstrb 0xF. Required: bvalid next cycle with OKAY; read of 0x08 returns 0xDEADBEEF with OKAY.
REQ-033 W before AW by 3 cycles: wdata 0x11223344, wstrb 0x3, then awaddr 0x04 with reg 1 = 0xAABBCCDD. Required: one bvalid only after AW; reg 1 reads 0xAABB3344.
REQ-034 Out of range, DEPTH=32: write to 0x80 gives bresp 2'b10 and all registers unchanged; read of 0x80 gives rdata 0 and rresp 2'b10.
REQ-035 Backpressure: bready and rready held low 5 cycles. Required: bvalid/rvalid and bresp/rdata stable throughout; awready and arready stay 0.
REQ-036 Concurrent read of 0x0C and write of 0x0C (0x5) in the same cycle, old value 0x9. Required: read returns 0x9; a later read returns 0x5.
REQ-037 areset pulsed after AW only, before W. Required: no bvalid, a later read of that address returns 0, and ready asserts 1 cycle after release.
